// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, result-entry layout and op encodings.
package alu_pkg;

  localparam int DATA_W  = 8;
  localparam int FLAG_W  = 3;
  localparam int ENTRY_W = DATA_W + FLAG_W;

  // Entry layout is {y, zero, negative, carry}; flag bit positions within it.
  localparam int ZERO_POS  = 2;
  localparam int NEG_POS   = 1;
  localparam int CARRY_POS = 0;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110
  } alu_op_e;

  localparam logic [DATA_W-1:0] ALU_DEFAULT_Y = 8'h1F;

endpackage

// File: rtl/alu_result_mem.sv
// Result-entry storage: one write port, asynchronous read port, contents never reset.
module alu_result_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Valid/ready FIFO of ALU result words with a sticky overflow flag.
// Optional sticky flag accumulator enabled by ALU_RESULT_FIFO_STICKY_FLAGS_EN.
module alu_result_fifo
  import alu_pkg::FLAG_W, alu_pkg::ZERO_POS, alu_pkg::NEG_POS, alu_pkg::CARRY_POS;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_y,
  input  logic                   in_zero,
  input  logic                   in_negative,
  input  logic                   in_carry,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_y,
  output logic                   out_zero,
  output logic                   out_negative,
  output logic                   out_carry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
  ,
  input  logic                   flags_clr,
  output logic [2:0]             sticky_flags
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + FLAG_W;

  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  // Ready/valid come only from count, so no out_ready -> in_ready path exists.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_entry = {in_y, in_zero, in_negative, in_carry};

  alu_result_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // Storage is never reset, so the head is masked to zero while empty.
  assign out_y        = out_valid ? rd_entry[ENTRY_W-1:FLAG_W] : '0;
  assign out_zero     = out_valid & rd_entry[ZERO_POS];
  assign out_negative = out_valid & rd_entry[NEG_POS];
  assign out_carry    = out_valid & rd_entry[CARRY_POS];
  assign count        = count_q;
  assign overflow     = overflow_q;

`ifdef ALU_RESULT_FIFO_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (flags_clr) begin
      sticky_d = '0;
    end else if (push) begin
      sticky_d = sticky_q | {in_zero, in_negative, in_carry};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule
